// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver and its matching transmitter.
// Contents:
//   uart_state_e  - frame FSM state encoding (IDLE, START, DATA, STOP)
//   LINE_IDLE     - logic level of an idle serial line
// -----------------------------------------------------------------------------
package uart_pkg;

  // Fixed 2-bit encoding so both UART directions decode states identically.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for a single asynchronous bit. Both flops reset to
// the idle line level (1) so no false start bit appears coming out of reset.
// Ports:
//   clk   in  1  rising-edge clock
//   rst_n in  1  asynchronous active-low reset
//   d_i   in  1  asynchronous input
//   q_o   out 1  synchronized output, two cycles behind d_i
// -----------------------------------------------------------------------------
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Metastability chain: first flop may go metastable, second resolves it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1-style UART receiver with mid-bit sampling.
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (4..65535)
//   DATA_BITS     data bits per frame (5..8)
// Ports:
//   clk        in  1          rising-edge clock
//   rst        in  1          asynchronous active-low reset
//   rx         in  1          asynchronous serial line, idle high
//   data       out DATA_BITS  last correctly framed word (LSB received first)
//   valid      out 1          one-cycle pulse when data updates
//   frame_err  out 1          one-cycle pulse on a bad (low) stop bit
//   busy       out 1          high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] I_ONE  = IW'(1);

  logic                 rx_s;

  uart_state_e          state_q,  state_d;
  logic [TW-1:0]        timer_q,  timer_d;
  logic [IW-1:0]        idx_q,    idx_d;
  logic [DATA_BITS-1:0] shift_q,  shift_d;
  logic [DATA_BITS-1:0] data_q,   data_d;
  logic                 valid_q,  valid_d;
  logic                 ferr_q,   ferr_d;
  logic                 busy_q,   busy_d;
  // Cleared after a framing error so a held-low (break) line cannot
  // retrigger; set again once the line is seen high.
  logic                 armed_q,  armed_d;

  sync2 u_sync2 (
    .clk   (clk),
    .rst_n (rst),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  // Next-state logic for the frame FSM, bit timer, shifter and output pulses.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    armed_d = armed_q;

    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        idx_d   = '0;
        armed_d = armed_q | (rx_s == LINE_IDLE);
        if (armed_q && (rx_s != LINE_IDLE)) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_START: begin
        if (timer_q == T_HALF) begin
          timer_d = '0;
          idx_d   = '0;
          // Line back high at mid start bit means a glitch: drop silently.
          if (rx_s != LINE_IDLE) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q + T_ONE;
        end
      end

      ST_DATA: begin
        if (timer_q == T_LAST) begin
          timer_d        = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == I_LAST) begin
            idx_d   = '0;
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + I_ONE;
          end
        end else begin
          timer_d = timer_q + T_ONE;
        end
      end

      ST_STOP: begin
        if (timer_q == T_LAST) begin
          // Leave at mid stop bit so a back-to-back start edge is not missed.
          timer_d = '0;
          state_d = ST_IDLE;
          if (rx_s == LINE_IDLE) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            armed_d = 1'b1;
          end else begin
            ferr_d  = 1'b1;
            armed_d = 1'b0;
          end
        end else begin
          timer_d = timer_q + T_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
        idx_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Frame FSM and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
      armed_q <= armed_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx with CLKS_PER_BIT = 8, DATA_BITS = 8.
// A vector table covers single frames; hand sequences cover back-to-back
// frames, start glitch, reset mid-frame and line break.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int CPB = 8;
  localparam int DB  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic [DB-1:0] data;
  logic          valid;
  logic          frame_err;
  logic          busy;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  int total = 0;
  int bad   = 0;

  // Monitor state, written only by the monitor process.
  int          nvalid    = 0;
  int          nferr     = 0;
  int          nboth     = 0;
  int          nbusy     = 0;
  int          nunstable = 0;
  int          cyc       = 0;
  logic [7:0]  prev_data = 8'h00;
  logic [7:0]  vq[$];
  int          tq[$];

  // Observe outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (valid) begin
      nvalid = nvalid + 1;
      vq.push_back(data);
      tq.push_back(cyc);
    end
    if (frame_err) nferr = nferr + 1;
    if (valid && frame_err) nboth = nboth + 1;
    if (busy) nbusy = nbusy + 1;
    if (rst && !valid && (data !== prev_data)) nunstable = nunstable + 1;
    prev_data = data;
  end

  task automatic check(input string name, input int act, input int req);
    total = total + 1;
    if (act != req) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic check_le(input string name, input int act, input int lim);
    total = total + 1;
    if (act > lim) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected at most %0d", name, act, lim);
    end
  endtask

  // Hold rx at one level for one bit time; returns at posedge + 1.
  task automatic hold_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_b);
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(b[i]);
    hold_bit(stop_b);
  endtask

  typedef struct {
    string      name;
    logic [7:0] byte_v;
    logic       stop_v;
    int         exp_v;
    int         exp_f;
    logic [7:0] exp_d;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int v0, f0, q0, b0;

    vecs[0] = '{"f55",   8'h55, 1'b1, 1, 0, 8'h55};
    vecs[1] = '{"fC6bad",8'hC6, 1'b0, 0, 1, 8'h55};
    vecs[2] = '{"f00",   8'h00, 1'b1, 1, 0, 8'h00};
    vecs[3] = '{"fFF",   8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[4] = '{"f01bad",8'h01, 1'b0, 0, 1, 8'hFF};
    vecs[5] = '{"f3C",   8'h3C, 1'b1, 1, 0, 8'h3C};

    // Reset state.
    rst = 1'b0;
    rx  = 1'b1;
    #2;
    check("rst_data",  int'(data), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_ferr",  int'(frame_err), 0);
    check("rst_busy",  int'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    hold_bit(1'b1);
    hold_bit(1'b1);

    // Table-driven single frames.
    for (int i = 0; i < 6; i++) begin
      v0 = nvalid;
      f0 = nferr;
      send_frame(vecs[i].byte_v, vecs[i].stop_v);
      hold_bit(1'b1);
      hold_bit(1'b1);
      check({vecs[i].name, "_valid"}, nvalid - v0, vecs[i].exp_v);
      check({vecs[i].name, "_ferr"},  nferr - f0,  vecs[i].exp_f);
      check({vecs[i].name, "_data"},  int'(data),  int'(vecs[i].exp_d));
      check({vecs[i].name, "_busy"},  int'(busy),  0);
    end

    // Back-to-back frames with no idle gap.
    v0 = nvalid;
    f0 = nferr;
    q0 = vq.size();
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    hold_bit(1'b1);
    hold_bit(1'b1);
    check("b2b_valid", nvalid - v0, 2);
    check("b2b_ferr",  nferr - f0, 0);
    check("b2b_d0",  (vq.size() >= q0 + 2) ? int'(vq[q0])     : -1, 8'hA3);
    check("b2b_d1",  (vq.size() >= q0 + 2) ? int'(vq[q0 + 1]) : -1, 8'h0F);
    check("b2b_gap", (tq.size() >= q0 + 2) ? (tq[q0 + 1] - tq[q0]) : -1, 80);

    // Start-bit glitch of 3 cycles.
    v0 = nvalid;
    f0 = nferr;
    b0 = nbusy;
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("glitch_valid", nvalid - v0, 0);
    check("glitch_ferr",  nferr - f0, 0);
    check_le("glitch_busy_max", nbusy - b0, 6);
    check("glitch_busy_seen", (nbusy - b0) > 0 ? 1 : 0, 1);
    check("glitch_idle", int'(busy), 0);

    // Reset in the middle of the data bits of 0x81.
    v0 = nvalid;
    f0 = nferr;
    hold_bit(1'b0);
    hold_bit(1'b1);
    hold_bit(1'b0);
    hold_bit(1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_data",  int'(data), 0);
    check("mid_rst_valid", int'(valid), 0);
    check("mid_rst_ferr",  int'(frame_err), 0);
    check("mid_rst_busy",  int'(busy), 0);
    rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    hold_bit(1'b1);
    hold_bit(1'b1);
    check("mid_rst_nopulse", (nvalid - v0) + (nferr - f0), 0);
    send_frame(8'h3C, 1'b1);
    hold_bit(1'b1);
    hold_bit(1'b1);
    check("post_rst_valid", nvalid - v0, 1);
    check("post_rst_data",  int'(data), 8'h3C);

    // Line break: rx low for 20 bit times.
    v0 = nvalid;
    f0 = nferr;
    repeat (20) hold_bit(1'b0);
    repeat (3) hold_bit(1'b1);
    check("break_ferr",  nferr - f0, 1);
    check("break_valid", nvalid - v0, 0);
    check("break_data",  int'(data), 8'h3C);
    send_frame(8'h7E, 1'b1);
    hold_bit(1'b1);
    hold_bit(1'b1);
    check("post_break_valid", nvalid - v0, 1);
    check("post_break_data",  int'(data), 8'h7E);

    // Global invariants gathered by the monitor.
    check("never_both",  nboth, 0);
    check("data_stable", nunstable, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter CLKS_PER_BIT, default 434, SHALL set clk cycles per serial bit (50 MHz / 115200 baud); legal range 4..65535.
REQ-003 Parameter DATA_BITS, default 8, SHALL set data bits per frame; legal range 5..8.
REQ-004 Port clk  input  1  SHALL be the rising-edge clock for all state.
REQ-005 Port rst  input  1  SHALL be the asynchronous reset, active-low.
REQ-006 Port rx  input  1  SHALL be the asynchronous serial line, idle high.
REQ-007 Port data  output  DATA_BITS  SHALL hold the last correctly framed word, LSB received first.
REQ-008 Port valid  output  1  SHALL pulse high for exactly one cycle when data updates.
REQ-009 Port frame_err  output  1  SHALL pulse high for exactly one cycle on a bad stop bit.
REQ-010 Port busy  output  1  SHALL be high whenever state is not IDLE.

Function
REQ-011 rx SHALL pass through a two-flop synchronizer before any use; rx_s denotes its output (2-cycle delay).
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-013 IDLE: on rx_s = 0, go to START, clear bit-timer.
REQ-014 START: at timer = CLKS_PER_BIT/2 - 1 (integer divide), sample rx_s; 0 -> DATA with timer and bit index cleared; 1 -> IDLE (glitch rejected, no pulse).
REQ-015 DATA: every CLKS_PER_BIT cycles after the start mid-point, sample rx_s into shift register bit[index], LSB first; after bit DATA_BITS-1 -> STOP.
REQ-016 STOP: CLKS_PER_BIT cycles after last data sample, sample rx_s; 1 -> load data, pulse valid; 0 -> pulse frame_err, data unchanged; both -> IDLE in the same cycle.
REQ-017 valid/frame_err SHALL assert in the cycle after the stop sample edge; never both high.
REQ-018 Return to IDLE at stop mid-point SHALL allow a back-to-back start bit to be detected without loss.
REQ-019 A line held low (break) SHALL produce frame_err once, then IDLE waits for rx_s = 1 before re-arming start detection.
REQ-020 Bit-timer width SHALL be $clog2(CLKS_PER_BIT); timer SHALL never exceed CLKS_PER_BIT-1 and wraps to 0 on each sample.
REQ-021 data SHALL be stable between valid pulses.

Reset
REQ-022 rst low SHALL immediately force state IDLE, timer 0, index 0, shift register 0, data 0, valid 0, frame_err 0, busy 0, synchronizer flops 1.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no valid/frame_err pulse; after release, the next falling edge on rx_s starts a new frame.

Structure
REQ-024 State enum (IDLE, START, DATA, STOP) SHALL live in shared package uart_pkg, for reuse by the matching uart_tx.
REQ-025 The two-flop synchronizer SHALL be a sub-module named sync2 (reset value 1, asynchronous active-low reset).
REQ-026 No other sub-modules; one FSM always_ff plus combinational next-state logic.

Verification (bench uses CLKS_PER_BIT = 8, DATA_BITS = 8)
REQ-027 Frame 0x55 (start, 10101010 LSB first, stop=1) -> one valid pulse, data = 0x55, frame_err never high.
REQ-028 Frames 0xA3 then 0x0F back-to-back, no idle gap -> two valid pulses, data 0xA3 then 0x0F, 80 cycles apart.
REQ-029 Frame 0xC6 with stop bit = 0 -> one frame_err pulse, no valid, data keeps previous value.
REQ-030 rx low for 3 cycles then high -> no valid, no frame_err, busy high at most 4+2 cycles, FSM back in IDLE.
REQ-031 rst low at mid-data of frame 0x81 -> all outputs 0 within same cycle, no pulse; next full frame 0x3C -> valid, data = 0x3C.
REQ-032 rx held low for 20 bit times -> exactly one frame_err; after rx returns high, frame 0x7E -> valid, data = 0x7E.
